// File: rtl/uart_pkg.sv
// Shared types and constants for the UART FIFO bridge.
package uart_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    localparam int UART_RX_EMPTY_BIT = 31;

    // simpleuart data words carry the byte in the low lane, upper bits zero.
    function automatic logic [31:0] uart_word(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and an occupancy counter.
// The caller gates push/pop; a push while full is only legal together with a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;

    // Storage carries no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign data_out = mem[rd_ptr_reg];
    assign full     = (level_reg == FULL_LEVEL);
    assign empty    = (level_reg == '0);
    assign level    = level_reg;

endmodule

// File: rtl/uart_fifo_bridge.sv
// Bus-side FIFO front end for simpleuart: TX FIFO drained through the we/wait
// handshake, RX bytes pulled from reg_dat_do into an RX FIFO with overrun flag.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        bus_tx_valid,
    input  logic [7:0]                  bus_tx_data,
    output logic                        bus_tx_ready,
    output logic                        bus_rx_valid,
    output logic [7:0]                  bus_rx_data,
    input  logic                        bus_rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        rx_overrun,
    input  logic                        rx_overrun_clr,
    output logic                        uart_dat_we,
    output logic [31:0]                 uart_dat_di,
    input  logic                        uart_dat_wait,
    output logic                        uart_dat_re,
    input  logic [31:0]                 uart_dat_do
);

    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;

    logic       rx_push;
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;

    tx_state_e  state_reg;
    tx_state_e  state_next;
    logic       we_reg;
    logic       we_next;
    logic [7:0] di_reg;
    logic [7:0] di_next;
    logic       overrun_reg;
    logic       overrun_next;

    logic       unused_do_bits;

    assign tx_push      = bus_tx_valid && bus_tx_ready;
    assign bus_tx_ready = !tx_full;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (tx_push),
        .pop      (tx_pop),
        .data_in  (bus_tx_data),
        .data_out (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= TX_IDLE;
            we_reg    <= 1'b0;
            di_reg    <= 8'h00;
        end else begin
            state_reg <= state_next;
            we_reg    <= we_next;
            di_reg    <= di_next;
        end
    end

    // A byte leaves the FIFO when idle, or back-to-back on the edge the UART accepts.
    always_comb begin
        state_next = state_reg;
        tx_pop     = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!uart_dat_wait) begin
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        we_next = (state_next == TX_SEND);
        di_next = tx_pop ? tx_head : di_reg;
    end

    assign uart_dat_we = we_reg;
    assign uart_dat_di = uart_word(di_reg);

    assign uart_dat_re    = !uart_dat_do[UART_RX_EMPTY_BIT];
    assign unused_do_bits = ^uart_dat_do[30:8];

    assign bus_rx_valid = !rx_empty;
    assign rx_pop       = bus_rx_valid && bus_rx_ready;
    assign rx_push      = uart_dat_re && (!rx_full || rx_pop);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (rx_push),
        .pop      (rx_pop),
        .data_in  (uart_dat_do[7:0]),
        .data_out (bus_rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
    );

    // A dropped byte outranks a simultaneous clear so no overrun is ever lost.
    always_comb begin
        overrun_next = overrun_reg;
        if (uart_dat_re && !rx_push) begin
            overrun_next = 1'b1;
        end else if (rx_overrun_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end

    assign rx_overrun = overrun_reg;

endmodule
